tcp_tx_ctrl: RTL and testbench

//  Control FSM for the TCP TX protocol-calc datapath. Accepts one scheduler request at a time and

---
 rtl/tcp_tx_ctrl.sv | 137 +++++++++++++
 tb/tb_tcp_tx_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_ctrl.sv
// Control FSM for the TCP TX protocol-calc datapath: one flow at a time through
// read-issue, read-response, calc, emit and state write-back.
module tcp_tx_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sched_tx_req_val,
  output logic             tx_sched_req_rdy,
  output logic             tx_tail_ptr_rd_req_val,
  input  logic             tx_tail_ptr_rd_req_rdy,
  output logic             curr_tx_state_rd_req_val,
  input  logic             curr_tx_state_rd_req_rdy,
  output logic             rx_state_rd_req_val,
  input  logic             rx_state_rd_req_rdy,
  output logic             tuple_rd_req_val,
  input  logic             tuple_rd_req_rdy,
  input  logic             tx_tail_ptr_rd_resp_val,
  output logic             tx_tail_ptr_rd_resp_rdy,
  input  logic             curr_tx_state_rd_resp_val,
  output logic             curr_tx_state_rd_resp_rdy,
  input  logic             rx_state_rd_resp_val,
  output logic             rx_state_rd_resp_rdy,
  input  logic             tuple_rd_resp_val,
  output logic             tuple_rd_resp_rdy,
  output logic             next_tx_state_wr_req_val,
  input  logic             next_tx_state_wr_req_rdy,
  output logic             tx_sched_update_val,
  input  logic             sched_tx_update_rdy,
  output logic             proto_calc_tx_val,
  input  logic             proto_calc_tx_rdy,
  output logic             ctrl_datap_store_flowid,
  output logic             ctrl_datap_store_state,
  output logic             ctrl_datap_store_tuple,
  output logic             ctrl_datap_store_calc,
  input  logic             datap_ctrl_produce_pkt,
  output logic [CNT_W-1:0] stat_pkt_cnt,
  output logic [CNT_W-1:0] stat_skip_cnt
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] CALC    = 3'd3;
  localparam logic [2:0] EMIT    = 3'd4;
  localparam logic [2:0] UPDATE  = 3'd5;

  // Handshake rule: a transfer happens on a rising clk edge where val=1 and rdy=1.
  // A val, once raised, is held until its transfer completes.
  logic [2:0] state, state_nxt;
  logic [3:0] issued, rd_val, rd_rdy, rd_hs, issued_nxt;
  logic       rd_all;
  logic       trio_done, tuple_done, trio_fire, tuple_fire, resp_all;
  logic       emit_hold, pkt_now, tx_hs, skip;
  logic       wr_done, upd_done, wr_hs, upd_hs, upd_all;
  logic       req_acc;

  assign req_acc    = (state == IDLE) && rst && sched_tx_req_val;

  // Read channel order: {tuple, rx, tx, tail}
  assign rd_rdy     = {tuple_rd_req_rdy, rx_state_rd_req_rdy,
                       curr_tx_state_rd_req_rdy, tx_tail_ptr_rd_req_rdy};
  assign rd_val     = {4{state == RD_REQ}} & ~issued;
  assign rd_hs      = rd_val & rd_rdy;
  assign issued_nxt = issued | rd_hs;
  assign rd_all     = &issued_nxt;

  // The trio is taken atomically; a partial set of valids is left waiting.
  assign trio_fire  = (state == RD_RESP) && !trio_done && tx_tail_ptr_rd_resp_val &&
                      curr_tx_state_rd_resp_val && rx_state_rd_resp_val;
  assign tuple_fire = (state == RD_RESP) && !tuple_done && tuple_rd_resp_val;
  assign resp_all   = (trio_done || trio_fire) && (tuple_done || tuple_fire);

  // produce_pkt is only meaningful in the first EMIT cycle; emit_hold remembers it.
  assign pkt_now    = (state == EMIT) && (emit_hold || datap_ctrl_produce_pkt);
  assign tx_hs      = pkt_now && proto_calc_tx_rdy;
  assign skip       = (state == EMIT) && !emit_hold && !datap_ctrl_produce_pkt;

  assign wr_hs      = next_tx_state_wr_req_val && next_tx_state_wr_req_rdy;
  assign upd_hs     = tx_sched_update_val && sched_tx_update_rdy;
  assign upd_all    = (wr_done || wr_hs) && (upd_done || upd_hs);

  assign tx_sched_req_rdy          = (state == IDLE) && rst;
  assign ctrl_datap_store_flowid   = req_acc;
  assign tx_tail_ptr_rd_req_val    = rd_val[0];
  assign curr_tx_state_rd_req_val  = rd_val[1];
  assign rx_state_rd_req_val       = rd_val[2];
  assign tuple_rd_req_val          = rd_val[3];
  assign tx_tail_ptr_rd_resp_rdy   = trio_fire;
  assign curr_tx_state_rd_resp_rdy = trio_fire;
  assign rx_state_rd_resp_rdy      = trio_fire;
  assign tuple_rd_resp_rdy         = tuple_fire;
  assign ctrl_datap_store_state    = trio_fire;
  assign ctrl_datap_store_tuple    = tuple_fire;
  assign ctrl_datap_store_calc     = (state == CALC);
  assign proto_calc_tx_val         = pkt_now;
  assign next_tx_state_wr_req_val  = (state == UPDATE) && !wr_done;
  assign tx_sched_update_val       = (state == UPDATE) && !upd_done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_acc)       state_nxt = RD_REQ;
      RD_REQ:  if (rd_all)        state_nxt = RD_RESP;
      RD_RESP: if (resp_all)      state_nxt = CALC;
      CALC:                       state_nxt = EMIT;
      EMIT:    if (tx_hs || skip) state_nxt = UPDATE;
      UPDATE:  if (upd_all)       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      issued        <= '0;
      trio_done     <= 1'b0;
      tuple_done    <= 1'b0;
      emit_hold     <= 1'b0;
      wr_done       <= 1'b0;
      upd_done      <= 1'b0;
      stat_pkt_cnt  <= '0;
      stat_skip_cnt <= '0;
    end else begin
      state      <= state_nxt;
      issued     <= (state == RD_REQ && !rd_all) ? issued_nxt : 4'b0000;
      trio_done  <= (state == RD_RESP && !resp_all) && (trio_done || trio_fire);
      tuple_done <= (state == RD_RESP && !resp_all) && (tuple_done || tuple_fire);
      emit_hold  <= pkt_now && !proto_calc_tx_rdy;
      wr_done    <= (state == UPDATE && !upd_all) && (wr_done || wr_hs);
      upd_done   <= (state == UPDATE && !upd_all) && (upd_done || upd_hs);
      if (tx_hs) stat_pkt_cnt  <= stat_pkt_cnt + CNT_W'(1);
      if (skip)  stat_skip_cnt <= stat_skip_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Bench for tcp_tx_ctrl: randomized memory/consumer responders, a request-count
// reference model feeding an expected queue, and a negedge monitor that scores each flow.
module tb_tcp_tx_ctrl;
  localparam int CW = 32;
  localparam int W  = 2 * CW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sched_tx_req_val, tx_sched_req_rdy;
  logic          tx_tail_ptr_rd_req_val, curr_tx_state_rd_req_val, rx_state_rd_req_val, tuple_rd_req_val;
  logic          tx_tail_ptr_rd_resp_rdy, curr_tx_state_rd_resp_rdy, rx_state_rd_resp_rdy, tuple_rd_resp_rdy;
  logic [3:0]    rd_req_rdy_v, resp_val_v, rd_req_val_v, resp_rdy_v;
  logic          next_tx_state_wr_req_val, next_tx_state_wr_req_rdy;
  logic          tx_sched_update_val, sched_tx_update_rdy;
  logic          proto_calc_tx_val, proto_calc_tx_rdy;
  logic          ctrl_datap_store_flowid, ctrl_datap_store_state, ctrl_datap_store_tuple, ctrl_datap_store_calc;
  logic          datap_ctrl_produce_pkt;
  logic [CW-1:0] stat_pkt_cnt, stat_skip_cnt;

  assign rd_req_val_v = {tuple_rd_req_val, rx_state_rd_req_val, curr_tx_state_rd_req_val, tx_tail_ptr_rd_req_val};
  assign resp_rdy_v   = {tuple_rd_resp_rdy, rx_state_rd_resp_rdy, curr_tx_state_rd_resp_rdy, tx_tail_ptr_rd_resp_rdy};

  tcp_tx_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .sched_tx_req_val(sched_tx_req_val), .tx_sched_req_rdy(tx_sched_req_rdy),
    .tx_tail_ptr_rd_req_val(tx_tail_ptr_rd_req_val), .tx_tail_ptr_rd_req_rdy(rd_req_rdy_v[0]),
    .curr_tx_state_rd_req_val(curr_tx_state_rd_req_val), .curr_tx_state_rd_req_rdy(rd_req_rdy_v[1]),
    .rx_state_rd_req_val(rx_state_rd_req_val), .rx_state_rd_req_rdy(rd_req_rdy_v[2]),
    .tuple_rd_req_val(tuple_rd_req_val), .tuple_rd_req_rdy(rd_req_rdy_v[3]),
    .tx_tail_ptr_rd_resp_val(resp_val_v[0]), .tx_tail_ptr_rd_resp_rdy(tx_tail_ptr_rd_resp_rdy),
    .curr_tx_state_rd_resp_val(resp_val_v[1]), .curr_tx_state_rd_resp_rdy(curr_tx_state_rd_resp_rdy),
    .rx_state_rd_resp_val(resp_val_v[2]), .rx_state_rd_resp_rdy(rx_state_rd_resp_rdy),
    .tuple_rd_resp_val(resp_val_v[3]), .tuple_rd_resp_rdy(tuple_rd_resp_rdy),
    .next_tx_state_wr_req_val(next_tx_state_wr_req_val), .next_tx_state_wr_req_rdy(next_tx_state_wr_req_rdy),
    .tx_sched_update_val(tx_sched_update_val), .sched_tx_update_rdy(sched_tx_update_rdy),
    .proto_calc_tx_val(proto_calc_tx_val), .proto_calc_tx_rdy(proto_calc_tx_rdy),
    .ctrl_datap_store_flowid(ctrl_datap_store_flowid), .ctrl_datap_store_state(ctrl_datap_store_state),
    .ctrl_datap_store_tuple(ctrl_datap_store_tuple), .ctrl_datap_store_calc(ctrl_datap_store_calc),
    .datap_ctrl_produce_pkt(datap_ctrl_produce_pkt),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_skip_cnt(stat_skip_cnt)
  );

  // control knobs owned by the main sequence
  int   pkt_mode;   // 0/1 forced produce_pkt, 2 random
  bit   lat_mode, hold_tx, to_flag, final_req;

  // scoreboard / monitor state
  int            n_tests = 0, n_fail = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  e;
  logic [CW-1:0] m_pkt, m_skip;
  logic          cur_pkt;
  logic [3:0]    hs_rd, hs_resp;
  logic          saw_calc;
  int            cyc, t_req, t_tx;
  int            f_flowid, f_state, f_tuple, f_calc, f_txv, f_txhs, f_wrv, f_wr, f_updv, f_upd;
  int            f_rd[4], f_resp[4];
  bit            await_idle, rst_seen, final_done, to_logged;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_flow();
    f_flowid = 0; f_state = 0; f_tuple = 0; f_calc = 0; f_txv = 0; f_txhs = 0;
    f_wrv = 0; f_wr = 0; f_updv = 0; f_upd = 0; t_tx = -1;
    for (int i = 0; i < 4; i++) begin f_rd[i] = 0; f_resp[i] = 0; end
  endtask

  // monitor: samples at negedge, pushes expectations on request accept, scores on flow end
  always @(negedge clk) begin
    if (!rst) begin
      if (!rst_seen) begin
        chk("reset_outputs", 64'({tx_sched_req_rdy, rd_req_val_v, resp_rdy_v, next_tx_state_wr_req_val,
              tx_sched_update_val, proto_calc_tx_val, ctrl_datap_store_flowid, ctrl_datap_store_state,
              ctrl_datap_store_tuple, ctrl_datap_store_calc}), 64'd0);
        chk("reset_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
        chk("reset_skip_cnt", 64'(stat_skip_cnt), 64'd0);
      end
      rst_seen = 1; exp_q.delete(); m_pkt = '0; m_skip = '0; await_idle = 0;
      hs_rd = '0; hs_resp = '0; saw_calc = 0; clear_flow();
    end else begin
      rst_seen = 0;
      cyc++;
      hs_rd    = rd_req_val_v & rd_req_rdy_v;
      hs_resp  = resp_val_v & resp_rdy_v;
      saw_calc = ctrl_datap_store_calc;
      if (await_idle && tx_sched_req_rdy) begin
        chk("req_to_idle_latency", 64'(cyc - t_req), 64'd6);
        await_idle = 0;
      end
      if (sched_tx_req_val && tx_sched_req_rdy) begin
        cur_pkt = (pkt_mode == 2) ? 1'($urandom_range(0, 1)) : (pkt_mode == 1);
        if (cur_pkt) m_pkt = m_pkt + 1; else m_skip = m_skip + 1;
        exp_q.push_back({cur_pkt, m_pkt, m_skip});
        t_req = cyc;
      end
      if (ctrl_datap_store_flowid) f_flowid++;
      if (ctrl_datap_store_state)  f_state++;
      if (ctrl_datap_store_tuple)  f_tuple++;
      if (ctrl_datap_store_calc)   f_calc++;
      if (proto_calc_tx_val) begin f_txv++; if (t_tx < 0) t_tx = cyc; end
      if (proto_calc_tx_val && proto_calc_tx_rdy) f_txhs++;
      if (next_tx_state_wr_req_val) f_wrv++;
      if (next_tx_state_wr_req_val && next_tx_state_wr_req_rdy) f_wr++;
      if (tx_sched_update_val) f_updv++;
      if (tx_sched_update_val && sched_tx_update_rdy) f_upd++;
      for (int i = 0; i < 4; i++) begin
        if (hs_rd[i]) f_rd[i]++;
        if (hs_resp[i]) f_resp[i]++;
      end
      if (|resp_rdy_v[2:0])
        chk("trio_rdy_atomic", 64'({resp_val_v[2:0], resp_rdy_v[2:0]}), 64'h3f);
      if (f_wr > 0 && f_upd > 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flow_end", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_handshakes", 64'(f_txhs), 64'(e[W-1]));
          if (!e[W-1]) chk("tx_val_on_skip", 64'(f_txv), 64'd0);
          chk("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'(e[2*CW-1:CW]));
          chk("stat_skip_cnt", 64'(stat_skip_cnt), 64'(e[CW-1:0]));
          chk("strobes_once", 64'({8'(f_flowid), 8'(f_state), 8'(f_tuple), 8'(f_calc)}), 64'h01010101);
          chk("reads_once", 64'({8'(f_rd[3]), 8'(f_rd[2]), 8'(f_rd[1]), 8'(f_rd[0])}), 64'h01010101);
          chk("resps_once", 64'({8'(f_resp[3]), 8'(f_resp[2]), 8'(f_resp[1]), 8'(f_resp[0])}), 64'h01010101);
          chk("wr_upd_once", 64'({8'(f_wr), 8'(f_upd)}), 64'h0101);
          if (lat_mode) begin
            if (e[W-1]) chk("req_to_tx_latency", 64'(t_tx - t_req), 64'd4);
            chk("wr_upd_val_cycles", 64'({8'(f_wrv), 8'(f_updv)}), 64'h0101);
            await_idle = 1;
          end
        end
        clear_flow();
      end
    end
    if (to_flag && !to_logged) begin
      to_logged = 1;
      chk("timeout", 64'd1, 64'd0);
    end
    if (final_req && !final_done) begin
      chk("final_pkt_cnt", 64'(stat_pkt_cnt), 64'(m_pkt));
      chk("final_skip_cnt", 64'(stat_skip_cnt), 64'(m_skip));
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      final_done = 1;
    end
  end

  // environment: memory responders, consumer ready, datapath produce_pkt
  int wait_c[4];
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      rd_req_rdy_v = '0; resp_val_v = '0;
      next_tx_state_wr_req_rdy = 0; sched_tx_update_rdy = 0; proto_calc_tx_rdy = 0;
      datap_ctrl_produce_pkt = 0;
      for (int i = 0; i < 4; i++) wait_c[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hs_resp[i]) resp_val_v[i] = 1'b0;
        if (hs_rd[i]) wait_c[i] = lat_mode ? 1 : int'($urandom_range(1, 5));
        if (wait_c[i] > 0) begin
          wait_c[i]--;
          if (wait_c[i] == 0) resp_val_v[i] = 1'b1;
        end
        rd_req_rdy_v[i] = lat_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      proto_calc_tx_rdy        = hold_tx ? 1'b0 : (lat_mode ? 1'b1 : ($urandom_range(0, 2) != 0));
      next_tx_state_wr_req_rdy = lat_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
      sched_tx_update_rdy      = lat_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
      datap_ctrl_produce_pkt   = saw_calc ? cur_pkt : 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic issue_req(input int mode);
    int n;
    pkt_mode = mode;
    @(posedge clk); #1;
    sched_tx_req_val = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_sched_req_rdy && rst) && n < 3000);
    if (n >= 3000) to_flag = 1;
    @(posedge clk); #1;
    sched_tx_req_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && tx_sched_req_rdy) && n < 3000);
    if (n >= 3000) to_flag = 1;
  endtask

  initial begin
    int n;
    rst = 1'b0; sched_tx_req_val = 1'b0; pkt_mode = 2;
    lat_mode = 0; hold_tx = 0; to_flag = 0; final_req = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // minimum-latency flows, packet then skip
    lat_mode = 1;
    issue_req(1); drain();
    issue_req(0); drain();
    lat_mode = 0;

    // randomized traffic with random backpressure and response delays
    for (int i = 0; i < 80; i++) begin
      issue_req(2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    // reset while a packet is being offered
    hold_tx = 1;
    issue_req(1);
    n = 0;
    while (!proto_calc_tx_val && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) to_flag = 1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk); #2 rst = 1'b1;
    hold_tx = 0;

    issue_req(1); issue_req(0);
    for (int i = 0; i < 10; i++) issue_req(2);
    drain();

    final_req = 1;
    n = 0;
    while (!final_done && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
